// File: rtl/raycast_pkg.sv
`default_nettype none
// ============================================================================
// Module      : raycast_pkg
// Description : Shared defaults, column record type and frame-buffer state
//               encoding for the raycast column store.
// Revision    : 1.0 - initial release
// ============================================================================
package raycast_pkg;

    localparam int NUM_COLS_DEF = 640;
    localparam int COL_W_DEF    = 10;
    localparam int HEIGHT_W_DEF = 9;
    localparam int LIGHT_W_DEF  = 2;
    localparam int TEX_W_DEF    = 4;
    localparam int STALL_W_DEF  = 8;

    // One column's raycast result, packed MSB-first as {height, light, tex}
    typedef struct packed {
        logic [HEIGHT_W_DEF-1:0] height;
        logic [LIGHT_W_DEF-1:0]  light;
        logic [TEX_W_DEF-1:0]    tex;
    } col_rec_t;

    localparam int REC_W_DEF = $bits(col_rec_t);

    // FILL: back bank accepting writes; PENDING: back bank complete, waiting for swap
    typedef enum logic [0:0] {
        ST_FILL    = 1'b0,
        ST_PENDING = 1'b1
    } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/column_bank.sv
`default_nettype none
// ============================================================================
// Module      : column_bank
// Description : Simple dual-port RAM, one write port and one registered read
//               port, holding one bank of column records.
// Revision    : 1.0 - initial release
// ============================================================================
module column_bank #(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 15
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port: callers guarantee waddr_i < DEPTH when we_i is high
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; output holds when not enabled
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/column_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : column_frame_buffer
// Description : Ping-pong store of per-column raycast results. The ray
//               pipeline fills the back bank while scan-out reads the front
//               bank; banks swap on a frame boundary once the back bank is
//               complete. Tracks repeated frames and out-of-range writes.
// Revision    : 1.0 - initial release
// ============================================================================
module column_frame_buffer
    import raycast_pkg::*;
#(
    parameter int NUM_COLS = NUM_COLS_DEF,
    parameter int COL_W    = COL_W_DEF,
    parameter int HEIGHT_W = HEIGHT_W_DEF,
    parameter int LIGHT_W  = LIGHT_W_DEF,
    parameter int TEX_W    = TEX_W_DEF,
    parameter int STALL_W  = STALL_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [COL_W-1:0]    wr_col_i,
    input  logic [HEIGHT_W-1:0] wr_height_i,
    input  logic [LIGHT_W-1:0]  wr_light_i,
    input  logic [TEX_W-1:0]    wr_tex_i,
    input  logic                wr_last_i,
    input  logic                frame_start_i,
    input  logic                rd_en_i,
    input  logic [COL_W-1:0]    rd_col_i,
    output logic [HEIGHT_W-1:0] rd_height_o,
    output logic [LIGHT_W-1:0]  rd_light_o,
    output logic [TEX_W-1:0]    rd_tex_o,
    output logic                rd_valid_o,
    output logic                front_valid_o,
    output logic                fill_req_o,
    output logic                bank_sel_o,
    output logic [STALL_W-1:0]  stall_count_o,
    output logic                col_err_o
);

    localparam int               REC_W       = HEIGHT_W + LIGHT_W + TEX_W;
    // One extra bit so NUM_COLS == 2**COL_W is still representable
    localparam logic [COL_W:0]   C_NUM_COLS  = NUM_COLS[COL_W:0];
    localparam logic [STALL_W-1:0] C_STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    fb_state_t          state_q, state_d;
    logic               bank_sel_q, bank_sel_d;
    logic               front_valid_q, front_valid_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               col_err_q, col_err_d;

    logic               rd_valid_q;
    logic               rd_zero_q;
    logic               rd_src_q;

    logic               w_wr_col_ok;
    logic               w_rd_col_ok;
    logic               w_wr_acc;
    logic [1:0]         w_we;
    logic [1:0]         w_re;
    logic [REC_W-1:0]   w_wdata;
    logic [REC_W-1:0]   w_rdata [2];
    logic [REC_W-1:0]   w_rd_rec;

    assign w_wr_col_ok = ({1'b0, wr_col_i} < C_NUM_COLS);
    assign w_rd_col_ok = ({1'b0, rd_col_i} < C_NUM_COLS);
    assign w_wr_acc    = wr_valid_i && (state_q == ST_FILL) && w_wr_col_ok;
    assign w_wdata     = {wr_height_i, wr_light_i, wr_tex_i};

    // Back bank is !bank_sel; reads always use bank_sel as it stands before
    // any swap taking effect on this same edge
    assign w_we[0] = w_wr_acc && bank_sel_q;
    assign w_we[1] = w_wr_acc && !bank_sel_q;
    assign w_re[0] = rd_en_i && w_rd_col_ok && !bank_sel_q;
    assign w_re[1] = rd_en_i && w_rd_col_ok && bank_sel_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            column_bank #(
                .DEPTH  (NUM_COLS),
                .ADDR_W (COL_W),
                .DATA_W (REC_W)
            ) u_bank (
                .clk     (clk),
                .we_i    (w_we[gi]),
                .waddr_i (wr_col_i),
                .wdata_i (w_wdata),
                .re_i    (w_re[gi]),
                .raddr_i (rd_col_i),
                .rdata_o (w_rdata[gi])
            );
        end
    endgenerate

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FILL;
            bank_sel_q    <= 1'b0;
            front_valid_q <= 1'b0;
            stall_q       <= '0;
            col_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bank_sel_q    <= bank_sel_d;
            front_valid_q <= front_valid_d;
            stall_q       <= stall_d;
            col_err_q     <= col_err_d;
        end
    end

    // Next-state: frame completion, swap on frame_start, repeat-frame counting
    always_comb begin
        state_d       = state_q;
        bank_sel_d    = bank_sel_q;
        front_valid_d = front_valid_q;
        stall_d       = stall_q;
        col_err_d     = col_err_q;

        if (wr_valid_i && !w_wr_col_ok) begin
            col_err_d = 1'b1;
        end

        unique case (state_q)
            ST_FILL: begin
                if (w_wr_acc && wr_last_i) begin
                    if (frame_start_i) begin
                        // Completion and boundary coincide: swap now, keep filling
                        bank_sel_d    = ~bank_sel_q;
                        front_valid_d = 1'b1;
                    end else begin
                        state_d = ST_PENDING;
                    end
                end else if (frame_start_i && front_valid_q && (stall_q != '1)) begin
                    stall_d = stall_q + C_STALL_ONE;
                end
            end
            ST_PENDING: begin
                if (frame_start_i) begin
                    bank_sel_d    = ~bank_sel_q;
                    front_valid_d = 1'b1;
                    state_d       = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Read strobe and output-source tracking; data holds between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
            rd_src_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_zero_q <= !w_rd_col_ok;
                rd_src_q  <= bank_sel_q;
            end
        end
    end

    assign w_rd_rec = rd_zero_q ? '0 : w_rdata[rd_src_q];
    assign {rd_height_o, rd_light_o, rd_tex_o} = w_rd_rec;

    assign rd_valid_o    = rd_valid_q;
    assign wr_ready_o    = (state_q == ST_FILL);
    assign fill_req_o    = (state_q == ST_FILL);
    assign front_valid_o = front_valid_q;
    assign bank_sel_o    = bank_sel_q;
    assign stall_count_o = stall_q;
    assign col_err_o     = col_err_q;

endmodule
`default_nettype wire

// File: tb/tb_column_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_column_frame_buffer
// Description : Self-checking bench for column_frame_buffer. A shadow model of
//               both banks produces expected read data, queued when a read is
//               issued and compared when rd_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_column_frame_buffer;
    import raycast_pkg::*;

    localparam int NC = 640;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [9:0] wr_col;
    logic [8:0] wr_height;
    logic [1:0] wr_light;
    logic [3:0] wr_tex;
    logic       wr_last;
    logic       frame_start;
    logic       rd_en;
    logic [9:0] rd_col;
    logic [8:0] rd_height;
    logic [1:0] rd_light;
    logic [3:0] rd_tex;
    logic       rd_valid;
    logic       front_valid;
    logic       fill_req;
    logic       bank_sel;
    logic [7:0] stall_count;
    logic       col_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    col_rec_t   model [2][NC];
    col_rec_t   exp_q [$];
    bit         exp_sel = 1'b0;

    column_frame_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid_i    (wr_valid),
        .wr_ready_o    (wr_ready),
        .wr_col_i      (wr_col),
        .wr_height_i   (wr_height),
        .wr_light_i    (wr_light),
        .wr_tex_i      (wr_tex),
        .wr_last_i     (wr_last),
        .frame_start_i (frame_start),
        .rd_en_i       (rd_en),
        .rd_col_i      (rd_col),
        .rd_height_o   (rd_height),
        .rd_light_o    (rd_light),
        .rd_tex_o      (rd_tex),
        .rd_valid_o    (rd_valid),
        .front_valid_o (front_valid),
        .fill_req_o    (fill_req),
        .bank_sel_o    (bank_sel),
        .stall_count_o (stall_count),
        .col_err_o     (col_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rd_valid pops one expected record
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected_valid", 32'd1, 32'd0);
            end else begin
                col_rec_t e;
                e = exp_q.pop_front();
                check("rd_data", {17'd0, rd_height, rd_light, rd_tex}, {17'd0, e});
            end
        end
    end

    // One write-channel cycle; exp_acc says whether the bench expects acceptance
    task automatic wr_cycle(input int col, input logic [8:0] h, input logic [1:0] l,
                            input logic [3:0] t, input logic last, input logic fs,
                            input logic exp_acc);
        wr_valid    = 1'b1;
        wr_col      = col[9:0];
        wr_height   = h;
        wr_light    = l;
        wr_tex      = t;
        wr_last     = last;
        frame_start = fs;
        if (exp_acc && col < NC) begin
            model[~exp_sel][col] = '{height: h, light: l, tex: t};
        end
        @(posedge clk); #1;
        wr_valid    = 1'b0;
        wr_last     = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic do_read(input int col);
        col_rec_t e;
        rd_en  = 1'b1;
        rd_col = col[9:0];
        if (col < NC) e = model[exp_sel][col];
        else          e = '0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        rd_en = 1'b0;
        check("rd_valid_latency", {31'd0, rd_valid}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_col = '0; wr_height = '0; wr_light = '0;
        wr_tex = '0; wr_last = 1'b0; frame_start = 1'b0; rd_en = 1'b0; rd_col = '0;
        idle(3);
        check("rst_wr_ready",    {31'd0, wr_ready},    32'd1);
        check("rst_fill_req",    {31'd0, fill_req},    32'd1);
        check("rst_front_valid", {31'd0, front_valid}, 32'd0);
        check("rst_bank_sel",    {31'd0, bank_sel},    32'd0);
        check("rst_rd_valid",    {31'd0, rd_valid},    32'd0);
        check("rst_rd_data",     {17'd0, rd_height, rd_light, rd_tex}, 32'd0);
        check("rst_stall",       {24'd0, stall_count}, 32'd0);
        check("rst_col_err",     {31'd0, col_err},     32'd0);
        reset = 1'b0;
        idle(1);

        // Initial fill into bank 1, with a frame boundary mid-fill
        for (int c = 0; c < NC; c++) begin
            logic [9:0] cv;
            cv = c[9:0];
            if (c == 320) begin
                pulse_fs();
                check("fill_fs_no_stall", {24'd0, stall_count}, 32'd0);
                check("fill_fs_no_swap",  {31'd0, bank_sel},    32'd0);
            end
            wr_cycle(c, cv[8:0], cv[1:0], cv[5:2], (c == NC-1), 1'b0, 1'b1);
        end
        check("pend_wr_ready",    {31'd0, wr_ready},    32'd0);
        check("pend_fill_req",    {31'd0, fill_req},    32'd0);
        check("pend_front_valid", {31'd0, front_valid}, 32'd0);
        pulse_fs();
        exp_sel = 1'b1;
        check("swap1_bank_sel",    {31'd0, bank_sel},    32'd1);
        check("swap1_front_valid", {31'd0, front_valid}, 32'd1);
        check("swap1_wr_ready",    {31'd0, wr_ready},    32'd1);
        do_read(100);
        idle(1);
        check("rd_hold_height", {23'd0, rd_height}, 32'd100);
        check("rd_hold_valid",  {31'd0, rd_valid},  32'd0);
        do_read(0);
        do_read(639);
        do_read(700);

        // Repeat frame three times
        for (int i = 0; i < 3; i++) begin
            pulse_fs();
            idle(2);
        end
        check("repeat_stall",    {24'd0, stall_count}, 32'd3);
        check("repeat_bank_sel", {31'd0, bank_sel},    32'd1);
        do_read(100);
        do_read(37);

        // Fill bank 0; final write coincides with frame_start
        for (int c = 0; c < NC-1; c++) begin
            logic [9:0] cv;
            cv = c[9:0];
            wr_cycle(c, ~cv[8:0], cv[3:2], cv[3:0], 1'b0, 1'b0, 1'b1);
        end
        wr_cycle(NC-1, 9'd7, 2'd2, 4'd9, 1'b1, 1'b1, 1'b1);
        exp_sel = 1'b0;
        check("coinc_bank_sel", {31'd0, bank_sel},    32'd0);
        check("coinc_stall",    {24'd0, stall_count}, 32'd3);
        do_read(639);
        check("coinc_wr_ready", {31'd0, wr_ready},    32'd1);
        do_read(12);

        // Fill bank 1 again, then attempt a write while PENDING
        for (int c = 0; c < NC; c++) begin
            logic [9:0] cv;
            cv = c[9:0];
            wr_cycle(c, cv[8:0] ^ 9'h0AA, cv[1:0], ~cv[3:0], (c == NC-1), 1'b0, 1'b1);
        end
        check("bp_wr_ready", {31'd0, wr_ready}, 32'd0);
        wr_cycle(5, 9'd3, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(1);
        pulse_fs();
        exp_sel = 1'b1;
        check("bp_bank_sel", {31'd0, bank_sel}, 32'd1);
        do_read(5);
        do_read(6);

        // Out-of-range column carrying wr_last
        wr_cycle(700, 9'd1, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0);
        check("oor_col_err",  {31'd0, col_err},  32'd1);
        check("oor_wr_ready", {31'd0, wr_ready}, 32'd1);
        pulse_fs();
        check("oor_no_swap",  {31'd0, bank_sel},    32'd1);
        check("oor_stall",    {24'd0, stall_count}, 32'd4);
        do_read(5);

        // Reset part-way through a fill
        for (int c = 0; c < 300; c++) begin
            logic [9:0] cv;
            cv = c[9:0];
            wr_cycle(c, cv[8:0], 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        end
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mrst_front_valid", {31'd0, front_valid}, 32'd0);
        check("mrst_wr_ready",    {31'd0, wr_ready},    32'd1);
        check("mrst_fill_req",    {31'd0, fill_req},    32'd1);
        check("mrst_stall",       {24'd0, stall_count}, 32'd0);
        check("mrst_col_err",     {31'd0, col_err},     32'd0);
        check("mrst_bank_sel",    {31'd0, bank_sel},    32'd0);
        pulse_fs();
        check("mrst_fs_no_stall", {24'd0, stall_count}, 32'd0);
        check("mrst_fs_no_front", {31'd0, front_valid}, 32'd0);

        idle(3);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
